// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing
// constants and the parity helper used by the host transmitter.
package ps2_pkg;

  typedef logic [2:0] ps2_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_RTS     = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  localparam int DEFAULT_CLK_FREQ   = 100_000_000;
  localparam int DEFAULT_INHIBIT_US = 100;
  localparam int DEFAULT_TIMEOUT_MS = 15;

  // Parity bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus a registered
// falling-edge detector. Level and fall pulse are aligned: both reflect
// the line three clocks after it changes.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic hist_reg;
  logic fall_reg;

  // Synchronize the line and flag a 1->0 transition of the synced value;
  // reset to the idle-high level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      hist_reg <= 1'b1;
      fall_reg <= 1'b0;
    end else begin
      meta_reg <= line;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
      fall_reg <= hist_reg & ~sync_reg;
    end
  end

  assign level = hist_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter. Inhibits the bus, issues
// request-to-send, shifts data/parity/stop on device falling clock edges,
// checks the device acknowledge and waits for the bus to go idle.
// All line drives are open-drain enables (1 = pull low).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int INHIBIT_US = DEFAULT_INHIBIT_US,
  parameter int TIMEOUT_MS = DEFAULT_TIMEOUT_MS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txData,
  input  logic       txStart,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkOe,
  output logic       ps2DataOe,
  output logic       txBusy,
  output logic       txDone,
  output logic       txError
);

  localparam int INHIBIT_CYCLES = CLK_FREQ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INHIBIT_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (ps2ClkIn),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (ps2DataIn),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  ps2_state_t       state_reg,   state_next;
  logic             clk_oe_reg,  clk_oe_next;
  logic             data_oe_reg, data_oe_next;
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;
  logic             error_reg,   error_next;
  logic [7:0]       data_reg,    data_next;
  logic             parity_reg,  parity_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic [TO_W-1:0]  to_cnt_reg,  to_cnt_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;

  // Next-state logic: frame sequencing, bit shifting and the overall timeout.
  always_comb begin
    state_next   = state_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    error_next   = 1'b0;
    data_next    = data_reg;
    parity_next  = parity_reg;
    inh_cnt_next = inh_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    bit_cnt_next = bit_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        busy_next    = 1'b0;
        if (txStart) begin
          // The byte is captured here; later txData changes are ignored.
          data_next    = txData;
          parity_next  = odd_parity(txData);
          inh_cnt_next = '0;
          to_cnt_next  = '0;
          bit_cnt_next = '0;
          clk_oe_next  = 1'b1;
          busy_next    = 1'b1;
          state_next   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_reg == INHIBIT_LAST) begin
          // Release clock and pull data low (start bit) in the same edge.
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b1;
          to_cnt_next  = '0;
          state_next   = ST_RTS;
        end else begin
          inh_cnt_next = inh_cnt_reg + INH_W'(1);
        end
      end

      ST_RTS, ST_SEND, ST_ACK, ST_RELEASE: begin
        if (to_cnt_reg == TIMEOUT_LAST) begin
          error_next   = 1'b1;
          busy_next    = 1'b0;
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          state_next   = ST_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
          if (state_reg == ST_RTS) begin
            bit_cnt_next = '0;
            state_next   = ST_SEND;
          end else if (state_reg == ST_SEND) begin
            // bit_cnt_reg holds the number of device falling edges seen so far.
            if (clk_fall) begin
              bit_cnt_next = bit_cnt_reg + 4'd1;
              if (bit_cnt_reg < 4'd8) begin
                data_oe_next = ~data_reg[bit_cnt_reg[2:0]];
              end else if (bit_cnt_reg == 4'd8) begin
                data_oe_next = ~parity_reg;
              end else begin
                data_oe_next = 1'b0;
                state_next   = ST_ACK;
              end
            end
          end else if (state_reg == ST_ACK) begin
            if (clk_fall) begin
              if (!data_level) begin
                state_next = ST_RELEASE;
              end else begin
                error_next = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
              end
            end
          end else begin
            if (clk_level && data_level) begin
              done_next  = 1'b1;
              busy_next  = 1'b0;
              state_next = ST_IDLE;
            end
          end
        end
      end

      default: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        busy_next    = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      data_reg    <= '0;
      parity_reg  <= 1'b0;
      inh_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
      data_reg    <= data_next;
      parity_reg  <= parity_next;
      inh_cnt_reg <= inh_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign ps2ClkOe  = clk_oe_reg;
  assign ps2DataOe = data_oe_reg;
  assign txBusy    = busy_reg;
  assign txDone    = done_reg;
  assign txError   = error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus model and a simple
// PS/2 device that clocks frames in and optionally acknowledges.
module tb_ps2_host_tx;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_MS = 15;
  localparam int INH_CYCLES = CLK_FREQ / 1_000_000 * INHIBIT_US;
  localparam int TO_CYCLES  = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int HALF       = CLK_FREQ / 12_500 / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] txData = 8'h00;
  logic       txStart = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2ClkIn, ps2DataIn;
  logic       ps2ClkOe, ps2DataOe;
  logic       txBusy, txDone, txError;

  // Open-drain bus: a line is high only when neither side pulls it low.
  assign ps2ClkIn  = ~ps2ClkOe & dev_clk;
  assign ps2DataIn = ~ps2DataOe & dev_data;

  ps2_host_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .txData    (txData),
    .txStart   (txStart),
    .ps2ClkIn  (ps2ClkIn),
    .ps2DataIn (ps2DataIn),
    .ps2ClkOe  (ps2ClkOe),
    .ps2DataOe (ps2DataOe),
    .txBusy    (txBusy),
    .txDone    (txDone),
    .txError   (txError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    bit         ack;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   error_cnt = 0;
  int   both_cnt = 0;
  int   overlap_cnt = 0;
  logic b;
  int   cnt;
  int   d0;
  int   e0;

  // Pulse monitor: counts done/error pulses and illegal overlaps.
  always @(negedge clk) begin
    if (txDone === 1'b1) done_cnt <= done_cnt + 1;
    if (txError === 1'b1) error_cnt <= error_cnt + 1;
    if (txDone === 1'b1 && txError === 1'b1) both_cnt <= both_cnt + 1;
    if ((txDone === 1'b1 || txError === 1'b1) && txBusy !== 1'b0) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic calc_parity(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic start_tx(input logic [7:0] d, input bit ack, input bit push);
    exp_t e;
    @(negedge clk);
    txData  = d;
    txStart = 1'b1;
    if (push) begin
      e.data   = d;
      e.parity = calc_parity(d);
      e.ack    = ack;
      sb.push_back(e);
    end
    @(negedge clk);
    txStart = 1'b0;
  endtask

  task automatic wait_rts();
    int n;
    n = 0;
    while (!(ps2ClkOe === 1'b0 && ps2DataOe === 1'b1) && n < 4 * INH_CYCLES) begin
      @(negedge clk);
      n++;
    end
    check("rts_seen", 32'(ps2DataOe), 32'd1);
  endtask

  task automatic dev_fall();
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b0;
  endtask

  task automatic dev_rise(output logic bit_seen);
    repeat (HALF) @(negedge clk);
    bit_seen = ps2DataIn;
    dev_clk  = 1'b1;
  endtask

  // Device side of one frame: collects start..stop, answers the ack slot,
  // then compares against the next scoreboard entry.
  task automatic device_txn();
    exp_t        e;
    logic [10:0] bits;
    logic        s;
    int          dc, ec, n;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard empty at device transaction");
      $fatal(1, "no expected transaction");
    end
    e  = sb.pop_front();
    dc = done_cnt;
    ec = error_cnt;
    wait_rts();
    bits[0] = ps2DataIn;
    for (int k = 1; k <= 10; k++) begin
      dev_fall();
      dev_rise(s);
      bits[k] = s;
    end
    if (e.ack) dev_data = 1'b0;
    dev_fall();
    dev_rise(s);
    dev_data = 1'b1;
    n = 0;
    while (txBusy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("start_bit", 32'(bits[0]), 32'd0);
    check("data_bits", 32'(bits[8:1]), 32'(e.data));
    check("parity_bit", 32'(bits[9]), 32'(e.parity));
    check("stop_bit", 32'(bits[10]), 32'd1);
    check("busy_after", 32'(txBusy), 32'd0);
    check("done_pulses", 32'(done_cnt - dc), e.ack ? 32'd1 : 32'd0);
    check("error_pulses", 32'(error_cnt - ec), e.ack ? 32'd0 : 32'd1);
    $display("txn data=%02h bits=%03h ack=%0d done=%0d error=%0d",
             e.data, bits, e.ack, done_cnt - dc, error_cnt - ec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_oe", 32'(ps2ClkOe), 32'd0);
    check("rst_data_oe", 32'(ps2DataOe), 32'd0);
    check("rst_busy", 32'(txBusy), 32'd0);
    check("rst_done", 32'(txDone), 32'd0);
    check("rst_error", 32'(txError), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xED: inhibit length, RTS handoff, full acknowledged frame
    start_tx(8'hED, 1'b1, 1'b1);
    check("busy_after_start", 32'(txBusy), 32'd1);
    cnt = 0;
    while (ps2ClkOe === 1'b1 && cnt < 4 * INH_CYCLES) begin
      cnt++;
      @(negedge clk);
    end
    check("inhibit_cycles", 32'(cnt), 32'(INH_CYCLES));
    check("rts_data_oe", 32'(ps2DataOe), 32'd1);
    check("rts_clk_oe", 32'(ps2ClkOe), 32'd0);
    device_txn();

    // 0x00 without acknowledge
    start_tx(8'h00, 1'b0, 1'b1);
    device_txn();

    // 0xF4 with a second start and changed txData while busy
    start_tx(8'hF4, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    txData  = 8'hFF;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    check("busy_ignores_start", 32'(txBusy), 32'd1);
    device_txn();

    // Device never clocks: timeout measured from RTS
    d0 = done_cnt;
    start_tx(8'h55, 1'b0, 1'b0);
    wait_rts();
    cnt = 0;
    while (txError !== 1'b1 && cnt < TO_CYCLES + 100) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles", 32'(cnt), 32'(TO_CYCLES));
    check("timeout_clk_oe", 32'(ps2ClkOe), 32'd0);
    check("timeout_data_oe", 32'(ps2DataOe), 32'd0);
    check("timeout_busy", 32'(txBusy), 32'd0);
    repeat (3) @(negedge clk);
    check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    $display("txn data=55 timeout after %0d cycles", cnt);

    // Reset at the 5th device falling edge
    d0 = done_cnt;
    e0 = error_cnt;
    start_tx(8'hED, 1'b1, 1'b0);
    wait_rts();
    for (int k = 1; k <= 5; k++) begin
      dev_fall();
      if (k < 5) dev_rise(b);
    end
    repeat (6) @(negedge clk);
    check("abort_pre_data_oe", 32'(ps2DataOe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_clk_oe", 32'(ps2ClkOe), 32'd0);
    check("abort_data_oe", 32'(ps2DataOe), 32'd0);
    check("abort_busy", 32'(txBusy), 32'd0);
    check("abort_done", 32'(txDone), 32'd0);
    check("abort_error", 32'(txError), 32'd0);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (50) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_error", 32'(error_cnt - e0), 32'd0);
    $display("txn data=ed aborted by reset at edge 5");
    start_tx(8'hED, 1'b1, 1'b1);
    device_txn();

    check("done_error_overlap", 32'(both_cnt), 32'd0);
    check("busy_during_pulse", 32'(overlap_cnt), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
